// File: rtl/ual_arbiter.sv
// Two-port arbiter sharing one combinational UAL: accepts one operation at a time,
// drives the UAL from registered operands and returns S/flag to the requesting port.
module ual_arbiter #(
  parameter int W          = 16,
  parameter int OPW        = 5,
  parameter int FLW        = 5,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           req0_valid_i,
  output logic           req0_ready_o,
  input  logic [W-1:0]   req0_a_i,
  input  logic [W-1:0]   req0_b_i,
  input  logic [OPW-1:0] req0_op_i,
  input  logic           req1_valid_i,
  output logic           req1_ready_o,
  input  logic [W-1:0]   req1_a_i,
  input  logic [W-1:0]   req1_b_i,
  input  logic [OPW-1:0] req1_op_i,
  output logic           rsp0_valid_o,
  input  logic           rsp0_ready_i,
  output logic [W-1:0]   rsp0_s_o,
  output logic [FLW-1:0] rsp0_flag_o,
  output logic           rsp1_valid_o,
  input  logic           rsp1_ready_i,
  output logic [W-1:0]   rsp1_s_o,
  output logic [FLW-1:0] rsp1_flag_o,
  output logic [W-1:0]   alu_a_o,
  output logic [W-1:0]   alu_b_o,
  output logic [OPW-1:0] alu_op_o,
  input  logic [W-1:0]   alu_s_i,
  input  logic [FLW-1:0] alu_flag_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e         state_q, state_d;
  logic           lastGrant_q, lastGrant_d;
  logic           owner_q, owner_d;
  logic [W-1:0]   aluA_q, aluA_d, aluB_q, aluB_d;
  logic [OPW-1:0] aluOp_q, aluOp_d;
  logic [W-1:0]   rsp0S_q, rsp0S_d, rsp1S_q, rsp1S_d;
  logic [FLW-1:0] rsp0Flag_q, rsp0Flag_d, rsp1Flag_q, rsp1Flag_d;
  logic           pick1, acc0, acc1, rspHs;

  // Round-robin favours port 1 only when port 0 was granted last.
  assign pick1 = FIXED_PRIO ? 1'b0 : (lastGrant_q == 1'b0);
  assign acc0  = req0_valid_i & req0_ready_o;
  assign acc1  = req1_valid_i & req1_ready_o;
  assign rspHs = (state_q == RESP) & (owner_q ? rsp1_ready_i : rsp0_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc0 || acc1) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (rspHs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Readys are gated by reset so every output reads zero while reset is held.
  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    if (state_q == IDLE && rst_ni) begin
      req0_ready_o = !(req1_valid_i && pick1);
      req1_ready_o = !req0_valid_i || pick1;
    end
    if (state_q == RESP) begin
      rsp0_valid_o = !owner_q;
      rsp1_valid_o = owner_q;
    end
  end

  always_comb begin
    lastGrant_d = lastGrant_q;
    owner_d     = owner_q;
    aluA_d      = aluA_q;
    aluB_d      = aluB_q;
    aluOp_d     = aluOp_q;
    rsp0S_d     = rsp0S_q;
    rsp0Flag_d  = rsp0Flag_q;
    rsp1S_d     = rsp1S_q;
    rsp1Flag_d  = rsp1Flag_q;
    if (acc0) begin
      aluA_d = req0_a_i; aluB_d = req0_b_i; aluOp_d = req0_op_i;
      owner_d = 1'b0; lastGrant_d = 1'b0;
    end else if (acc1) begin
      aluA_d = req1_a_i; aluB_d = req1_b_i; aluOp_d = req1_op_i;
      owner_d = 1'b1; lastGrant_d = 1'b1;
    end
    if (state_q == ISSUE) begin
      if (owner_q) begin
        rsp1S_d = alu_s_i; rsp1Flag_d = alu_flag_i;
      end else begin
        rsp0S_d = alu_s_i; rsp0Flag_d = alu_flag_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lastGrant_q <= 1'b1;
      owner_q     <= 1'b0;
      aluA_q      <= '0;
      aluB_q      <= '0;
      aluOp_q     <= '0;
      rsp0S_q     <= '0;
      rsp0Flag_q  <= '0;
      rsp1S_q     <= '0;
      rsp1Flag_q  <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      owner_q     <= owner_d;
      aluA_q      <= aluA_d;
      aluB_q      <= aluB_d;
      aluOp_q     <= aluOp_d;
      rsp0S_q     <= rsp0S_d;
      rsp0Flag_q  <= rsp0Flag_d;
      rsp1S_q     <= rsp1S_d;
      rsp1Flag_q  <= rsp1Flag_d;
    end
  end

  assign alu_a_o     = aluA_q;
  assign alu_b_o     = aluB_q;
  assign alu_op_o    = aluOp_q;
  assign rsp0_s_o    = rsp0S_q;
  assign rsp0_flag_o = rsp0Flag_q;
  assign rsp1_s_o    = rsp1S_q;
  assign rsp1_flag_o = rsp1Flag_q;

endmodule

// File: tb/tb_ual_arbiter.sv
// Bench for ual_arbiter: a stand-in UAL plus a transaction-level model of who should be
// served and what each response must carry; a second instance exercises fixed priority.
module tb_ual_arbiter;
  localparam int W = 16, OPW = 5, FLW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic req0Valid, req0Ready, req1Valid, req1Ready;
  logic [W-1:0] req0A, req0B, req1A, req1B;
  logic [OPW-1:0] req0Op, req1Op;
  logic rsp0Valid, rsp0Ready, rsp1Valid, rsp1Ready;
  logic [W-1:0] rsp0S, rsp1S, aluA, aluB, aluS;
  logic [FLW-1:0] rsp0Flag, rsp1Flag, aluFlag;
  logic [OPW-1:0] aluOp;

  logic fpV0, fpV1, fpReq0Ready, fpReq1Ready, fpRsp0Valid, fpRsp1Valid;
  logic [W-1:0] fpRsp0S, fpRsp1S, fpAluA, fpAluB, fpAluS;
  logic [FLW-1:0] fpRsp0Flag, fpRsp1Flag, fpAluFlag;
  logic [OPW-1:0] fpAluOp;

  int nChecks = 0;
  int nFails = 0;
  int expLast = 1;

  // Stand-in UAL: arbitrary but deterministic arithmetic with a 5-bit flag word.
  function automatic logic [FLW+W-1:0] ualRef(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [OPW-1:0] op);
    logic [W:0] r;
    logic [FLW-1:0] f;
    case (op)
      5'd0:    r = {1'b0, a} + {1'b0, b};
      5'd1:    r = {1'b0, a} - {1'b0, b};
      5'd2:    r = {1'b0, a & b};
      5'd3:    r = {1'b0, a | b};
      default: r = {1'b0, a ^ b};
    endcase
    f = {^r[W-1:0], r[W-1], (r[W-1:0] == '0), r[W], op[0]};
    return {f, r[W-1:0]};
  endfunction

  assign {aluFlag, aluS}     = ualRef(aluA, aluB, aluOp);
  assign {fpAluFlag, fpAluS} = ualRef(fpAluA, fpAluB, fpAluOp);

  ual_arbiter #(.W(W), .OPW(OPW), .FLW(FLW), .FIXED_PRIO(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(req0Valid), .req0_ready_o(req0Ready), .req0_a_i(req0A), .req0_b_i(req0B),
    .req0_op_i(req0Op),
    .req1_valid_i(req1Valid), .req1_ready_o(req1Ready), .req1_a_i(req1A), .req1_b_i(req1B),
    .req1_op_i(req1Op),
    .rsp0_valid_o(rsp0Valid), .rsp0_ready_i(rsp0Ready), .rsp0_s_o(rsp0S), .rsp0_flag_o(rsp0Flag),
    .rsp1_valid_o(rsp1Valid), .rsp1_ready_i(rsp1Ready), .rsp1_s_o(rsp1S), .rsp1_flag_o(rsp1Flag),
    .alu_a_o(aluA), .alu_b_o(aluB), .alu_op_o(aluOp), .alu_s_i(aluS), .alu_flag_i(aluFlag)
  );

  ual_arbiter #(.W(W), .OPW(OPW), .FLW(FLW), .FIXED_PRIO(1'b1)) dutFp (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(fpV0), .req0_ready_o(fpReq0Ready), .req0_a_i(req0A), .req0_b_i(req0B),
    .req0_op_i(req0Op),
    .req1_valid_i(fpV1), .req1_ready_o(fpReq1Ready), .req1_a_i(req1A), .req1_b_i(req1B),
    .req1_op_i(req1Op),
    .rsp0_valid_o(fpRsp0Valid), .rsp0_ready_i(rsp0Ready), .rsp0_s_o(fpRsp0S),
    .rsp0_flag_o(fpRsp0Flag),
    .rsp1_valid_o(fpRsp1Valid), .rsp1_ready_i(rsp1Ready), .rsp1_s_o(fpRsp1S),
    .rsp1_flag_o(fpRsp1Flag),
    .alu_a_o(fpAluA), .alu_b_o(fpAluB), .alu_op_o(fpAluOp), .alu_s_i(fpAluS),
    .alu_flag_i(fpAluFlag)
  );

  // One complete transaction: request, ISSUE, RESP with optional backpressure, release.
  task automatic runOp(input bit v0, input bit v1,
                       input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [OPW-1:0] op0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [OPW-1:0] op1,
                       input int hold);
    int winner;
    bit p1;
    logic [W-1:0] wa, wb;
    logic [OPW-1:0] wop;
    logic [FLW+W-1:0] expRes, gotRes;
    @(negedge clk);
    req0Valid = v0; req1Valid = v1;
    req0A = a0; req0B = b0; req0Op = op0;
    req1A = a1; req1B = b1; req1Op = op1;
    rsp0Ready = 1'b0; rsp1Ready = 1'b0;
    #1;
    p1 = (expLast == 0);
    winner = (v0 && v1) ? (p1 ? 1 : 0) : (v1 ? 1 : 0);
    nChecks++;
    if ({req0Ready, req1Ready} !== {!(v1 && p1), (!v0 || p1)}) begin
      nFails++;
      $display("[TB] FAIL grant_ready: got %b expected %b", {req0Ready, req1Ready},
               {!(v1 && p1), (!v0 || p1)});
    end
    wa = winner ? a1 : a0; wb = winner ? b1 : b0; wop = winner ? op1 : op0;
    expRes = ualRef(wa, wb, wop);
    @(negedge clk);
    req0Valid = 1'b0; req1Valid = 1'b0;
    req0A = W'($urandom); req1A = W'($urandom); req0B = W'($urandom); req1B = W'($urandom);
    #1;
    nChecks++;
    if ({req0Ready, req1Ready, rsp0Valid, rsp1Valid} !== 4'b0000) begin
      nFails++;
      $display("[TB] FAIL issue_ctrl: got %b expected 0000", {req0Ready, req1Ready, rsp0Valid, rsp1Valid});
    end
    nChecks++;
    if ({aluA, aluB, aluOp} !== {wa, wb, wop}) begin
      nFails++;
      $display("[TB] FAIL issue_operands: got %h expected %h", {aluA, aluB, aluOp}, {wa, wb, wop});
    end
    expLast = winner;
    @(negedge clk);
    #1;
    for (int k = 0; k <= hold; k++) begin
      gotRes = winner ? {rsp1Flag, rsp1S} : {rsp0Flag, rsp0S};
      nChecks++;
      if ({rsp0Valid, rsp1Valid, req0Ready, req1Ready} !== {(winner == 0), (winner == 1), 2'b00}) begin
        nFails++;
        $display("[TB] FAIL resp_ctrl[%0d]: got %b expected %b", k,
                 {rsp0Valid, rsp1Valid, req0Ready, req1Ready}, {(winner == 0), (winner == 1), 2'b00});
      end
      nChecks++;
      if (gotRes !== expRes || {aluA, aluB, aluOp} !== {wa, wb, wop}) begin
        nFails++;
        $display("[TB] FAIL resp_data[%0d]: got %h/%h expected %h/%h", k, gotRes,
                 {aluA, aluB, aluOp}, expRes, {wa, wb, wop});
      end
      if (k < hold) begin
        rsp0Ready = (winner == 1); rsp1Ready = (winner == 0);
        req0Valid = 1'($urandom); req1Valid = 1'($urandom);
        @(negedge clk);
        #1;
      end
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
    rsp0Ready = (winner == 0); rsp1Ready = (winner == 1);
    @(negedge clk);
    #1;
    gotRes = winner ? {rsp1Flag, rsp1S} : {rsp0Flag, rsp0S};
    nChecks++;
    if ({rsp0Valid, rsp1Valid, req0Ready, req1Ready} !== 4'b0011 || gotRes !== expRes) begin
      nFails++;
      $display("[TB] FAIL release: got %b/%h expected 0011/%h",
               {rsp0Valid, rsp1Valid, req0Ready, req1Ready}, gotRes, expRes);
    end
    rsp0Ready = 1'b0; rsp1Ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0Valid = 0; req1Valid = 0; fpV0 = 0; fpV1 = 0;
    req0A = 0; req0B = 0; req0Op = 0; req1A = 0; req1B = 0; req1Op = 0;
    rsp0Ready = 0; rsp1Ready = 0;
    #2;
    nChecks++;
    if ({req0Ready, req1Ready, rsp0Valid, rsp1Valid, rsp0S, rsp0Flag, rsp1S, rsp1Flag,
         aluA, aluB, aluOp} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {req0Ready, req1Ready, rsp0Valid,
               rsp1Valid, rsp0S, rsp0Flag, rsp1S, rsp1Flag, aluA, aluB, aluOp});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expLast = 1;
  endtask

  task automatic test_single_op();
    runOp(1, 0, 16'h0003, 16'h0004, 5'd0, 16'h1111, 16'h2222, 5'd2, 0);
    nChecks++;
    if ({rsp0S, rsp1Valid} !== {16'h0007, 1'b0}) begin
      nFails++;
      $display("[TB] FAIL single_add: got %h expected 0007", rsp0S);
    end
  endtask

  task automatic test_tie_alternation();
    for (int i = 0; i < 4; i++)
      runOp(1, 1, W'($urandom), W'($urandom), 5'd0, W'($urandom), W'($urandom), 5'd1, 0);
  endtask

  task automatic test_backpressure();
    runOp(0, 1, 16'h1234, 16'h00FF, 5'd3, 16'hA5A5, 16'h5A5A, 5'd4, 5);
  endtask

  task automatic test_flags();
    logic [FLW+W-1:0] expRes;
    expRes = ualRef(16'h0000, 16'h0001, 5'd1);
    runOp(0, 1, 16'h0000, 16'h0000, 5'd0, 16'h0000, 16'h0001, 5'd1, 1);
    nChecks++;
    if ({rsp1Flag, rsp1S} !== {expRes[FLW+W-1:W], 16'hFFFF}) begin
      nFails++;
      $display("[TB] FAIL sub_flags: got %h/%h expected %h/ffff", rsp1Flag, rsp1S, expRes[FLW+W-1:W]);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req0Valid = 1'b1; req0A = 16'hBEEF; req0B = 16'h0101; req0Op = 5'd0;
    @(negedge clk);
    req0Valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if ({req0Ready, req1Ready, rsp0Valid, rsp1Valid, rsp0S, rsp0Flag, rsp1S, rsp1Flag,
         aluA, aluB, aluOp} !== '0) begin
      nFails++;
      $display("[TB] FAIL midop_reset_outputs: got %h expected 0", {req0Ready, req1Ready,
               rsp0Valid, rsp1Valid, rsp0S, rsp0Flag, rsp1S, rsp1Flag, aluA, aluB, aluOp});
    end
    rst_n = 1'b1;
    expLast = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nChecks++;
      if ({rsp0Valid, rsp1Valid} !== 2'b00) begin
        nFails++;
        $display("[TB] FAIL aborted_no_resp[%0d]: got %b expected 00", i, {rsp0Valid, rsp1Valid});
      end
    end
    runOp(1, 1, 16'h0010, 16'h0020, 5'd0, 16'h0030, 16'h0040, 5'd0, 0);
  endtask

  task automatic test_random();
    int pat;
    for (int i = 0; i < 30; i++) begin
      pat = $urandom_range(1, 3);
      runOp(pat[0], pat[1], W'($urandom), W'($urandom), OPW'($urandom_range(0, 7)),
            W'($urandom), W'($urandom), OPW'($urandom_range(0, 7)), $urandom_range(0, 3));
    end
  endtask

  task automatic test_fixed_prio();
    int grants = 0;
    int cycles = 0;
    logic [FLW+W-1:0] expRes;
    @(negedge clk);
    req0A = 16'h0F0F; req0B = 16'h0101; req0Op = 5'd0;
    req1A = 16'h7777; req1B = 16'h1111; req1Op = 5'd1;
    expRes = ualRef(16'h0F0F, 16'h0101, 5'd0);
    rsp0Ready = 1'b1; rsp1Ready = 1'b1;
    fpV0 = 1'b1; fpV1 = 1'b1;
    while (grants < 4 && cycles < 40) begin
      #1;
      nChecks++;
      if (fpRsp1Valid !== 1'b0 || (fpRsp0Valid && {fpRsp0Flag, fpRsp0S} !== expRes)) begin
        nFails++;
        $display("[TB] FAIL fp_resp: got %b/%h expected 0/%h", fpRsp1Valid, {fpRsp0Flag, fpRsp0S}, expRes);
      end
      if (fpReq0Ready || fpReq1Ready) begin
        grants++;
        nChecks++;
        if ({fpReq0Ready, fpReq1Ready} !== 2'b10) begin
          nFails++;
          $display("[TB] FAIL fp_grant: got %b expected 10", {fpReq0Ready, fpReq1Ready});
        end
      end
      cycles++;
      @(negedge clk);
    end
    nChecks++;
    if (grants !== 4) begin
      nFails++;
      $display("[TB] FAIL fp_grant_count: got %0d expected 4", grants);
    end
    fpV0 = 1'b0; fpV1 = 1'b0; rsp0Ready = 1'b0; rsp1Ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_tie_alternation();
    test_backpressure();
    test_flags();
    test_async_reset();
    test_random();
    test_fixed_prio();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
